// File: rtl/fpmac_scheduler.sv
// Sequencer that drives the shared FPMac datapath one dot product at a time,
// sweeping (i, j) in row-major order to build S = A * B^T over a valid/ready port.
module fpmac_scheduler #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int OUT_WIDTH   = 16,
  parameter  int DATA_LENGTH = 4,
  parameter  int ROWS        = 4,
  parameter  int COLS        = 4,
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int VW          = DATA_WIDTH * DATA_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [RW-1:0]        a_addr,
  input  logic [VW-1:0]        a_data,
  output logic [CW-1:0]        b_addr,
  input  logic [VW-1:0]        b_data,
  output logic [VW-1:0]        mac_in_1,
  output logic [VW-1:0]        mac_in_2,
  input  logic [OUT_WIDTH-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [RW-1:0]        res_row,
  output logic [CW-1:0]        res_col
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]    state;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          last_row;
  logic          last_col;

  assign last_row = (row_idx == RW'(ROWS - 1));
  assign last_col = (col_idx == CW'(COLS - 1));

  // The counters only move on a handshake, so they already are registered
  // addresses that are valid during ADDR and held through OUT.
  assign a_addr = row_idx;
  assign b_addr = col_idx;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_idx   <= '0;
      col_idx   <= '0;
      done      <= 1'b0;
      mac_in_1  <= '0;
      mac_in_2  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          row_idx <= '0;
          col_idx <= '0;
          if (start) state <= S_ADDR;
        end
        S_ADDR: state <= S_LOAD;
        S_LOAD: begin
          mac_in_1 <= a_data;
          mac_in_2 <= b_data;
          state    <= S_MAC;
        end
        S_MAC: begin
          res_data  <= mac_out;
          res_row   <= row_idx;
          res_col   <= col_idx;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_ADDR;
            if (last_col) begin
              col_idx <= '0;
              if (last_row) begin
                row_idx <= '0;
                done    <= 1'b1;
                state   <= S_IDLE;
              end else begin
                row_idx <= row_idx + 1'b1;
              end
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
